restoring_divider: RTL
======================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division, sampled on the clk rising edge.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned dividend, sampled with start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned divisor, sampled with start.
REQ-007 The block SHALL have port quotient, output, WIDTH bits: registered result.
REQ-008 The block SHALL have port remainder, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking quotient and remainder valid.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag, valid with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1 and divisor!=0, the block SHALL, at that edge:
- load the operands;
- clear the partial remainder;
- clear the iteration counter;
- enter CALC.
REQ-014 In IDLE with start=1 and divisor==0, the block SHALL, at that edge:
- set quotient to all ones;
- set remainder to dividend;
- set div_by_zero to 1;
- enter DONE.
REQ-015 Each CALC cycle SHALL perform one restoring step:
- shift the next dividend MSB into a WIDTH+1-bit partial remainder;
- subtract the divisor, zero-extended to WIDTH+1 bits;
- if the result is non-negative (bit WIDTH = 0), keep the difference and shift in quotient bit 1;
- otherwise restore the partial remainder and shift in quotient bit 0.
REQ-016 CALC SHALL last exactly WIDTH cycles, after which the state SHALL move to DONE with quotient and remainder final.
- Latency: done is high in the cycle following edge k+WIDTH, where k is the start edge.
REQ-017 busy SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-018 done SHALL be 1 only in DONE, which SHALL last one cycle and then return unconditionally to IDLE.
REQ-019 start SHALL be ignored in CALC and DONE; no queuing, and in-flight operands SHALL NOT be disturbed.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-021 div_by_zero SHALL be cleared on any accepted start with a nonzero divisor.
REQ-022 For every accepted operand pair with divisor!=0, results SHALL satisfy:
- dividend == quotient*divisor + remainder;
- remainder < divisor.
REQ-023 start held high continuously SHALL start a new division every WIDTH+2 cycles, with each accepted from IDLE.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE and drive busy=0, done=0, div_by_zero=0, quotient=0 and remainder=0, independent of clk.
REQ-025 Reset asserted mid-CALC SHALL abandon the division with no done pulse.
REQ-026 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state encoding (IDLE, CALC, DONE);
- the default WIDTH constant.
REQ-028 The WIDTH+1-bit subtract-and-borrow SHALL be a separate combinational sub-module, sub_cla.
- It is a carry-look-ahead adder computing A + ~B + 1.
- It outputs the difference and the borrow, derived as inverted carry-out.
REQ-029 The iteration counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap during CALC.

Verification
REQ-030 The bench SHALL cover:
- dividend=13, divisor=3, start pulse -> busy for 4 cycles, done pulse, quotient=4, remainder=1, div_by_zero=0.
- 15/1 -> quotient=15, remainder=0; then 0/5 -> quotient=0, remainder=0.
- 7/0 -> done one cycle after start, quotient=4'hF, remainder=7, div_by_zero=1; then 9/2 -> quotient=4, remainder=1, div_by_zero=0.
- 10/3 started, then 6/2 driven with start during CALC -> only quotient=3, remainder=1 reported, a single done pulse.
- rst_n low during 2nd CALC cycle of 12/5 -> all outputs 0 immediately, no done; next 12/5 -> quotient=2, remainder=2.
- exhaustive sweep of all 256 operand pairs -> REQ-022 holds for every pair, divide-by-zero per REQ-014.

Source files
------------

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and default operand width.
package restoring_divider_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/restoring_divider_sub_cla.sv
// Combinational subtractor a - b as a carry-look-ahead sum a + ~b + 1.
// borrow is the inverted carry-out (1 when a < b).
module sub_cla #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry is expanded from generate/propagate terms with carry-in = 1.
  always_comb begin
    logic cg;
    logic cp;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      cg = 1'b0;
      cp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cg = cg | (cp & g[j]);
        cp = cp & p[j];
      end
      c[i+1] = cg | cp;
    end
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];
endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
//   state | meaning
//   IDLE  | waiting for start; operands and divide-by-zero resolved here
//   CALC  | one shift/subtract/restore step per cycle, WIDTH cycles
//   DONE  | results valid, one-cycle done pulse
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd, dvs, quo, prem;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted, diff;
  logic             borrow, last;
  logic [WIDTH-1:0] prem_nxt, quo_nxt;
  logic             unused_diff_msb;

  // The restored remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra bit.
  assign shifted         = {prem, dvd[WIDTH-1]};
  assign prem_nxt        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt         = {quo[WIDTH-2:0], ~borrow};
  assign last            = (cnt == CW'(WIDTH - 1));
  assign unused_diff_msb = diff[WIDTH];

  sub_cla #(.W(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              dvd         <= dividend;
              dvs         <= divisor;
              prem        <= '0;
              quo         <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          dvd  <= dvd << 1;
          prem <= prem_nxt;
          quo  <= quo_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            quotient  <= quo_nxt;
            remainder <= prem_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
